axi_rdata_router: RTL and testbench
===================================

Name: axi_rdata_router

Overview:
Parametrised AXI read-data (R channel) crossbar return path. It routes NUM_SLAVES slave R channels to NUM_MASTERS master R channels. Arbitration is round-robin with per-burst locking from the first beat to the RLAST handshake. The destination master is decoded from the one-hot master field in the upper bits of the extended slave ID. It replaces the fixed 6-slave/3-master fixed-priority read-data mux in the AXI interconnect and adds decode-error dropping and a drop counter.

Parameters:
NUM_SLAVES, 6, number of slave R ports (2..16)
NUM_MASTERS, 3, number of master R ports (1..8); also the width of the one-hot master field
ID_BITS, 4, master-side RID width; slave-side ID width IDS_BITS = ID_BITS + NUM_MASTERS (derived localparam)
DATA_BITS, 32, RDATA width
CNT_BITS, 16, width of drop counter

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
RID_S  in  NUM_SLAVES*IDS_BITS  slave RIDs, slave k at [k*IDS_BITS +: IDS_BITS]; bits [IDS_BITS-1:ID_BITS] = one-hot master, [ID_BITS-1:0] = master RID
RDATA_S  in  NUM_SLAVES*DATA_BITS  slave RDATA
RRESP_S  in  NUM_SLAVES*2  slave RRESP
RLAST_S  in  NUM_SLAVES  slave RLAST
RVALID_S  in  NUM_SLAVES  slave RVALID
RREADY_S  out  NUM_SLAVES  slave RREADY
RID_M  out  ID_BITS  RID broadcast to all masters
RDATA_M  out  DATA_BITS  RDATA broadcast
RRESP_M  out  2  RRESP broadcast
RLAST_M  out  1  RLAST broadcast
RVALID_M  out  NUM_MASTERS  per-master RVALID
RREADY_M  in  NUM_MASTERS  per-master RREADY
grant  out  NUM_SLAVES  one-hot currently selected slave (0 when none)
drop_count  out  CNT_BITS  saturating count of dropped (mis-addressed) beats

Behaviour:
- Reset (rst=1, async): FSM IDLE; rr pointer = 0 (slave 0 highest priority); drop_count=0. Outputs settle to RVALID_M=0, RREADY_S=0, grant=0, and RID_M/RDATA_M/RRESP_M/RLAST_M=0.
- FSM IDLE: combinational arbitration among RVALID_S. Winner = first asserted index at or after pointer, wrapping modulo NUM_SLAVES.
  - Winner is granted in the same cycle (zero added latency). A beat may complete in the grant cycle.
  - If a non-last beat handshakes, or no handshake occurs, go to LOCKED with the winner stored.
  - If the grant-cycle beat is RLAST and handshakes, stay IDLE.
  - No RVALID_S: grant=0, all outputs 0.
- FSM LOCKED: grant = stored slave, regardless of other RVALID_S or the locked slave deasserting RVALID mid-burst. Return to IDLE on the handshake of a beat with RLAST_S[g]=1.
- Pointer update: on every RLAST handshake (routed or dropped), pointer = g+1 mod NUM_SLAVES.
- Routing for granted g, mst = RID_S[g] master field:
  - mst exactly one-hot: RVALID_M[m] = RVALID_S[g] for the set bit m, other RVALID_M = 0; RREADY_S[g] = RVALID_S[g] & RREADY_M[m]; data/ID/resp/last muxed from g. RID_M = low ID_BITS of RID_S[g].
  - mst zero or multi-hot (decode error): all RVALID_M=0; RREADY_S[g]=1; beat discarded. drop_count += 1 per discarded beat, saturating at all-ones. Lock/unlock rules unchanged.
- Non-granted slaves: RREADY_S=0. No RREADY is ever asserted toward an idle slave.
- Reset asserted mid-burst: lock and pointer cleared immediately; the partially delivered burst is abandoned (system-level reset).
- Per-beat master decode: a burst whose master field changes mid-burst is routed beat by beat.

Optional Feature:
RDATA_REG_SLICE_EN: when defined, a 2-entry skid buffer sits between the mux and the master outputs.
- Master-side RID/RDATA/RRESP/RLAST/RVALID come from flops: +1 cycle latency, full throughput (one beat/cycle sustained).
- Upstream ready = buffer not full, registered; the buffer holds the destination master index per entry.
- Lock release, pointer update and drop counting happen at upstream acceptance.
- Reset empties the buffer.
When not defined: purely combinational data path as above (zero latency).

Test Plan:
- Reset then idle: RVALID_S=0 -> RVALID_M=0, RREADY_S=0, grant=0, drop_count=0.
- Slave 2 sends a 4-beat burst to master 1 (field 3'b010), RREADY_M=3'b111 -> RVALID_M=3'b010 for 4 cycles, RDATA_M matches, RREADY_S[2] high 4 cycles, grant=6'b000100; return to IDLE after beat 4.
- Slaves 0 and 4 both valid with single-beat RLAST bursts, repeated -> grants alternate 0,4,0,4; pointer wraps correctly past slave 5.
- Lock: slave 1 burst mid-way, RVALID_S[1] dropped for 2 cycles while slave 0 valid -> grant stays slave 1; slave 0 served only after slave 1 RLAST handshake.
- Backpressure: RREADY_M[0]=0 for 3 cycles during a master-0 burst -> RREADY_S stays 0, RDATA_M held stable, no beat lost.
- Decode error: slave 3 sends 2 beats with master field 3'b000, then 1 beat with 3'b011 -> all RVALID_M=0, RREADY_S[3]=1, drop_count=3; with count preset near max, it saturates at 16'hFFFF.

Source files
------------

// File: rtl/axi_rdata_router.sv
// AXI read-data return path: round-robin slave R channels onto broadcast master R channels.
// Optional RDATA_REG_SLICE_EN inserts a 2-entry skid buffer in front of the master outputs.
module axi_rdata_router #(
  parameter int NUM_SLAVES  = 6,
  parameter int NUM_MASTERS = 3,
  parameter int ID_BITS     = 4,
  parameter int DATA_BITS   = 32,
  parameter int CNT_BITS    = 16
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic [NUM_SLAVES*(ID_BITS+NUM_MASTERS)-1:0]   RID_S,
  input  logic [NUM_SLAVES*DATA_BITS-1:0]               RDATA_S,
  input  logic [NUM_SLAVES*2-1:0]                       RRESP_S,
  input  logic [NUM_SLAVES-1:0]                         RLAST_S,
  input  logic [NUM_SLAVES-1:0]                         RVALID_S,
  output logic [NUM_SLAVES-1:0]                         RREADY_S,
  output logic [ID_BITS-1:0]                            RID_M,
  output logic [DATA_BITS-1:0]                          RDATA_M,
  output logic [1:0]                                    RRESP_M,
  output logic                                          RLAST_M,
  output logic [NUM_MASTERS-1:0]                        RVALID_M,
  input  logic [NUM_MASTERS-1:0]                        RREADY_M,
  output logic [NUM_SLAVES-1:0]                         grant,
  output logic [CNT_BITS-1:0]                           drop_count
);

  // state  | meaning
  // IDLE   | no burst in progress; arbitrate among RVALID_S each cycle
  // LOCKED | burst in progress; grant held on lock_q until its RLAST handshake

  localparam int IDS_BITS = ID_BITS + NUM_MASTERS;
  localparam int SW = $clog2(NUM_SLAVES);
  localparam int MW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam logic [SW:0] NS = (SW+1)'(NUM_SLAVES);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t              state_q;
  logic [SW-1:0]       lock_q;
  logic [SW-1:0]       ptr_q;
  logic [CNT_BITS-1:0] drop_q;

  logic                   arb_found;
  logic [SW-1:0]          arb_idx;
  logic [SW:0]            arb_j;
  logic                   active;
  logic [SW-1:0]          sel;
  logic [IDS_BITS-1:0]    sel_id;
  logic [DATA_BITS-1:0]   sel_data;
  logic [1:0]             sel_resp;
  logic                   sel_last;
  logic                   sel_valid;
  logic [NUM_MASTERS-1:0] mst;
  logic                   mst_ok;
  logic [MW-1:0]          mst_idx;
  logic                   up_ready;
  logic                   take;
  logic                   hs;
  logic                   route_hs;
  logic                   drop_hs;

  // first requester at or after the pointer, wrapping
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    arb_j     = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      arb_j = {1'b0, ptr_q} + (SW+1)'(i);
      if (arb_j >= NS) arb_j = arb_j - NS;
      if (!arb_found && RVALID_S[arb_j[SW-1:0]]) begin
        arb_found = 1'b1;
        arb_idx   = arb_j[SW-1:0];
      end
    end
  end

  assign active    = !rst && ((state_q == LOCKED) || arb_found);
  assign sel       = (state_q == LOCKED) ? lock_q : arb_idx;
  assign sel_id    = RID_S[sel*IDS_BITS +: IDS_BITS];
  assign sel_data  = RDATA_S[sel*DATA_BITS +: DATA_BITS];
  assign sel_resp  = RRESP_S[sel*2 +: 2];
  assign sel_last  = RLAST_S[sel];
  assign sel_valid = active && RVALID_S[sel];
  assign mst       = sel_id[IDS_BITS-1:ID_BITS];
  assign mst_ok    = $onehot(mst);

  always_comb begin
    mst_idx = '0;
    for (int m = 0; m < NUM_MASTERS; m++)
      if (mst[m]) mst_idx = MW'(m);
  end

  // mis-addressed beats are always accepted so the slave can drain
  assign take     = mst_ok ? (sel_valid && up_ready) : active;
  assign hs       = take && sel_valid;
  assign route_hs = hs && mst_ok;
  assign drop_hs  = hs && !mst_ok;

  always_comb begin
    RREADY_S = '0;
    grant    = '0;
    for (int s = 0; s < NUM_SLAVES; s++) begin
      RREADY_S[s] = take && (sel == SW'(s));
      grant[s]    = active && (sel == SW'(s));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      lock_q  <= '0;
      ptr_q   <= '0;
      drop_q  <= '0;
    end else begin
      if (hs && sel_last) begin
        state_q <= IDLE;
        ptr_q   <= (sel == SW'(NUM_SLAVES-1)) ? '0 : sel + 1'b1;
      end else if (active) begin
        state_q <= LOCKED;
        lock_q  <= sel;
      end
      if (drop_hs && (drop_q != '1)) drop_q <= drop_q + 1'b1;
    end
  end

  assign drop_count = drop_q;

`ifdef RDATA_REG_SLICE_EN
  logic [ID_BITS-1:0]   b_id   [2];
  logic [DATA_BITS-1:0] b_data [2];
  logic [1:0]           b_resp [2];
  logic                 b_last [2];
  logic [MW-1:0]        b_mst  [2];
  logic                 wr_q;
  logic                 rd_q;
  logic [1:0]           cnt_q;
  logic                 pop;

  assign up_ready = (cnt_q != 2'd2);
  assign pop      = (cnt_q != 2'd0) && RREADY_M[b_mst[rd_q]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= 1'b0;
      rd_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      if (route_hs) wr_q <= ~wr_q;
      if (pop) rd_q <= ~rd_q;
      cnt_q <= cnt_q + {1'b0, route_hs} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (route_hs) begin
      b_id[wr_q]   <= sel_id[ID_BITS-1:0];
      b_data[wr_q] <= sel_data;
      b_resp[wr_q] <= sel_resp;
      b_last[wr_q] <= sel_last;
      b_mst[wr_q]  <= mst_idx;
    end
  end

  always_comb begin
    RVALID_M = '0;
    RID_M    = '0;
    RDATA_M  = '0;
    RRESP_M  = '0;
    RLAST_M  = 1'b0;
    if (cnt_q != 2'd0) begin
      RVALID_M[b_mst[rd_q]] = 1'b1;
      RID_M   = b_id[rd_q];
      RDATA_M = b_data[rd_q];
      RRESP_M = b_resp[rd_q];
      RLAST_M = b_last[rd_q];
    end
  end
`else
  assign up_ready = RREADY_M[mst_idx];

  always_comb begin
    RVALID_M = '0;
    RID_M    = '0;
    RDATA_M  = '0;
    RRESP_M  = '0;
    RLAST_M  = 1'b0;
    if (sel_valid && mst_ok) RVALID_M = mst;
    if (active) begin
      RID_M   = sel_id[ID_BITS-1:0];
      RDATA_M = sel_data;
      RRESP_M = sel_resp;
      RLAST_M = sel_last;
    end
  end
`endif

endmodule

// File: tb/tb_axi_rdata_router.sv
// Directed bench for axi_rdata_router (default combinational build).
module tb_axi_rdata_router;
  localparam int NS  = 6;
  localparam int NM  = 3;
  localparam int IB  = 4;
  localparam int DB  = 32;
  localparam int CB  = 16;
  localparam int IDS = IB + NM;

  logic              clk = 1'b0;
  logic              rst;
  logic [NS*IDS-1:0] rid_s;
  logic [NS*DB-1:0]  rdata_s;
  logic [NS*2-1:0]   rresp_s;
  logic [NS-1:0]     rlast_s;
  logic [NS-1:0]     rvalid_s;
  logic [NS-1:0]     rready_s;
  logic [IB-1:0]     rid_m;
  logic [DB-1:0]     rdata_m;
  logic [1:0]        rresp_m;
  logic              rlast_m;
  logic [NM-1:0]     rvalid_m;
  logic [NM-1:0]     rready_m;
  logic [NS-1:0]     grant;
  logic [CB-1:0]     drop_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axi_rdata_router #(
    .NUM_SLAVES(NS), .NUM_MASTERS(NM), .ID_BITS(IB), .DATA_BITS(DB), .CNT_BITS(CB)
  ) dut (
    .clk(clk), .rst(rst),
    .RID_S(rid_s), .RDATA_S(rdata_s), .RRESP_S(rresp_s), .RLAST_S(rlast_s),
    .RVALID_S(rvalid_s), .RREADY_S(rready_s),
    .RID_M(rid_m), .RDATA_M(rdata_m), .RRESP_M(rresp_m), .RLAST_M(rlast_m),
    .RVALID_M(rvalid_m), .RREADY_M(rready_m),
    .grant(grant), .drop_count(drop_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic drive(input int k, input logic v, input logic [2:0] mst, input logic [3:0] id,
                       input logic [31:0] d, input logic last);
    rvalid_s[k]            = v;
    rid_s[k*IDS +: IDS]    = {mst, id};
    rdata_s[k*DB +: DB]    = d;
    rresp_s[k*2 +: 2]      = 2'(k);
    rlast_s[k]             = last;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  int exp_g [4] = '{4, 0, 4, 0};

  initial begin
    rst      = 1'b1;
    rid_s    = '0;
    rdata_s  = '0;
    rresp_s  = '0;
    rlast_s  = '0;
    rvalid_s = '0;
    rready_m = 3'b111;
    drive(0, 1'b1, 3'b001, 4'h1, 32'h1234_5678, 1'b1);

    // reset holds everything quiet even with a requester present
    @(negedge clk);
    chk("rst_grant",    32'(grant),      32'h0);
    chk("rst_rvalid_m", 32'(rvalid_m),   32'h0);
    chk("rst_rready_s", 32'(rready_s),   32'h0);
    chk("rst_rdata_m",  rdata_m,         32'h0);
    chk("rst_drop",     32'(drop_count), 32'h0);
    tick;
    rst      = 1'b0;
    rvalid_s = '0;
    @(negedge clk);
    chk("idle_grant",    32'(grant),    32'h0);
    chk("idle_rvalid_m", 32'(rvalid_m), 32'h0);
    chk("idle_rready_s", 32'(rready_s), 32'h0);
    tick;

    // slave 2 -> master 1, 4 beats
    for (int b = 0; b < 4; b++) begin
      drive(2, 1'b1, 3'b010, 4'h5, 32'hA000_0000 + b, 1'(b == 3));
      @(negedge clk);
      chk("t2_rvalid_m", 32'(rvalid_m), 32'h2);
      chk("t2_rready_s", 32'(rready_s), 32'h4);
      chk("t2_grant",    32'(grant),    32'h4);
      chk("t2_rdata_m",  rdata_m,       32'hA000_0000 + b);
      chk("t2_rid_m",    32'(rid_m),    32'h5);
      chk("t2_rresp_m",  32'(rresp_m),  32'h2);
      chk("t2_rlast_m",  32'(rlast_m),  32'(b == 3));
      tick;
    end
    rvalid_s = '0;
    @(negedge clk);
    chk("t2_idle_grant", 32'(grant), 32'h0);
    tick;

    // pointer is now 3: slaves 0 and 4 alternate starting with 4
    drive(0, 1'b1, 3'b001, 4'h1, 32'h0000_1000, 1'b1);
    drive(4, 1'b1, 3'b100, 4'h4, 32'h0000_4000, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t3_grant",    32'(grant),    32'(1 << exp_g[i]));
      chk("t3_rvalid_m", 32'(rvalid_m), (exp_g[i] == 4) ? 32'h4 : 32'h1);
      chk("t3_rdata_m",  rdata_m,       (exp_g[i] == 4) ? 32'h0000_4000 : 32'h0000_1000);
      tick;
    end
    rvalid_s = '0;

    // lock: slave 1 burst, pauses while slave 0 requests
    drive(1, 1'b1, 3'b100, 4'h7, 32'hB000_0000, 1'b0);
    @(negedge clk);
    chk("t4_b0_grant",    32'(grant),    32'h2);
    chk("t4_b0_rvalid_m", 32'(rvalid_m), 32'h4);
    tick;
    rvalid_s[1] = 1'b0;
    drive(0, 1'b1, 3'b001, 4'h2, 32'hC000_0000, 1'b1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("t4_gap_grant",    32'(grant),    32'h2);
      chk("t4_gap_rready_s", 32'(rready_s), 32'h0);
      chk("t4_gap_rvalid_m", 32'(rvalid_m), 32'h0);
      tick;
    end
    drive(1, 1'b1, 3'b100, 4'h7, 32'hB000_0001, 1'b0);
    @(negedge clk);
    chk("t4_b1_grant",  32'(grant), 32'h2);
    chk("t4_b1_rdata",  rdata_m,    32'hB000_0001);
    tick;
    drive(1, 1'b1, 3'b100, 4'h7, 32'hB000_0002, 1'b1);
    @(negedge clk);
    chk("t4_b2_grant",    32'(grant),    32'h2);
    chk("t4_b2_rready_s", 32'(rready_s), 32'h2);
    tick;
    rvalid_s[1] = 1'b0;
    @(negedge clk);
    chk("t4_s0_grant",    32'(grant),    32'h1);
    chk("t4_s0_rready_s", 32'(rready_s), 32'h1);
    chk("t4_s0_rdata",    rdata_m,       32'hC000_0000);
    tick;
    rvalid_s = '0;

    // backpressure on master 0 during a slave 5 burst
    drive(5, 1'b1, 3'b001, 4'h9, 32'hD000_0000, 1'b0);
    @(negedge clk);
    chk("t5_b0_grant", 32'(grant), 32'h20);
    tick;
    drive(5, 1'b1, 3'b001, 4'h9, 32'hD000_0001, 1'b0);
    rready_m = 3'b110;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t5_bp_rready_s", 32'(rready_s), 32'h0);
      chk("t5_bp_rvalid_m", 32'(rvalid_m), 32'h1);
      chk("t5_bp_rdata",    rdata_m,       32'hD000_0001);
      tick;
    end
    rready_m = 3'b111;
    @(negedge clk);
    chk("t5_b1_rready_s", 32'(rready_s), 32'h20);
    chk("t5_b1_rdata",    rdata_m,       32'hD000_0001);
    tick;
    drive(5, 1'b1, 3'b001, 4'h9, 32'hD000_0002, 1'b1);
    @(negedge clk);
    chk("t5_b2_rdata", rdata_m,       32'hD000_0002);
    chk("t5_b2_rlast", 32'(rlast_m),  32'h1);
    tick;
    rvalid_s = '0;

    // decode errors from slave 3: 000, 000, 011
    for (int b = 0; b < 3; b++) begin
      drive(3, 1'b1, (b == 2) ? 3'b011 : 3'b000, 4'h3, 32'hE000_0000 + b, 1'(b == 2));
      @(negedge clk);
      chk("t6_rvalid_m", 32'(rvalid_m), 32'h0);
      chk("t6_rready_s", 32'(rready_s), 32'h8);
      chk("t6_grant",    32'(grant),    32'h8);
      tick;
    end
    rvalid_s = '0;
    @(negedge clk);
    chk("t6_drop_count", 32'(drop_count), 32'h3);
    chk("t6_idle_grant", 32'(grant),      32'h0);
    tick;

    // saturate the drop counter with a long mis-addressed burst
    drive(3, 1'b1, 3'b000, 4'h3, 32'hF000_0000, 1'b0);
    repeat (65540) @(posedge clk);
    #1;
    @(negedge clk);
    chk("t7_drop_sat", 32'(drop_count), 32'hFFFF);
    chk("t7_grant",    32'(grant),      32'h8);
    tick;
    // master field turns valid mid-burst: this beat is routed
    drive(3, 1'b1, 3'b001, 4'h3, 32'hF000_0001, 1'b1);
    @(negedge clk);
    chk("t7_route_rvalid_m", 32'(rvalid_m), 32'h1);
    chk("t7_route_rready_s", 32'(rready_s), 32'h8);
    chk("t7_route_rdata",    rdata_m,       32'hF000_0001);
    tick;
    rvalid_s = '0;
    @(negedge clk);
    chk("t7_drop_hold",  32'(drop_count), 32'hFFFF);
    chk("t7_idle_grant", 32'(grant),      32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
